// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter:
// FSM state encoding, grant-owner values and default timing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PIPE_ACC = 2'd1,
        DMA_ACC  = 2'd2
    } arb_state_e;

    localparam logic GRANT_PIPE = 1'b0;
    localparam logic GRANT_DMA  = 1'b1;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_CNT_WIDTH   = 4;
    localparam int unsigned FREEZE_CNT_WIDTH    = 32;
    localparam int unsigned DMA_GRANT_CNT_WIDTH = 16;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for one memory access: loads on grant,
// counts down while the access is active, flags zero.
module mem_wait_counter #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [CNT_WIDTH-1:0] load_value_i,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares data_memory between the pipeline MEM stage and a DMA/debug port,
// freezing the pipeline until its own access completes.
// Optional performance counters are enabled with `define ARB_PERF_COUNT_EN.
module data_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_Pipe_Address,
    input  logic [DATA_WIDTH-1:0] i_Pipe_Write_Data,
    output logic [DATA_WIDTH-1:0] o_Pipe_Read_Data,
    output logic                  o_Pipe_Done,
    output logic                  o_Freeze,
    input  logic                  i_Dma_Request,
    input  logic                  i_Dma_Write,
    input  logic [DATA_WIDTH-1:0] i_Dma_Address,
    input  logic [DATA_WIDTH-1:0] i_Dma_Write_Data,
    output logic [DATA_WIDTH-1:0] o_Dma_Read_Data,
    output logic                  o_Dma_Done,
    output logic                  o_Mem_Read_Enable,
    output logic                  o_Mem_Write_Enable,
    output logic [DATA_WIDTH-1:0] o_Mem_Address,
    output logic [DATA_WIDTH-1:0] o_Mem_Write_Data,
    input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data
`ifdef ARB_PERF_COUNT_EN
    ,
    output logic [FREEZE_CNT_WIDTH-1:0]    o_Freeze_Cycles,
    output logic [DMA_GRANT_CNT_WIDTH-1:0] o_Dma_Grants
`endif
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  cnt_load, cnt_dec, cnt_zero;
    logic                  pipe_req, acc_active;

    assign pipe_req = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;

    mem_wait_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_wait_counter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (cnt_load),
        .dec_i        (cnt_dec),
        .load_value_i (CNT_WIDTH'(WAIT_CYCLES)),
        .zero_o       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DMA;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    // Round-robin grant in IDLE; ACC runs until the wait counter reaches zero.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pipe_req && (!i_Dma_Request || (last_grant_q == GRANT_DMA))) begin
                    state_d      = PIPE_ACC;
                    last_grant_d = GRANT_PIPE;
                    addr_d       = i_Pipe_Address;
                    wdata_d      = i_Pipe_Write_Data;
                    write_d      = i_Sig_Memory_Write_Enable;
                    cnt_load     = 1'b1;
                end else if (i_Dma_Request) begin
                    state_d      = DMA_ACC;
                    last_grant_d = GRANT_DMA;
                    addr_d       = i_Dma_Address;
                    wdata_d      = i_Dma_Write_Data;
                    write_d      = i_Dma_Write;
                    cnt_load     = 1'b1;
                end
            end
            PIPE_ACC, DMA_ACC: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the memory side immediately so an aborted access never writes.
    assign acc_active = !reset && ((state_q == PIPE_ACC) || (state_q == DMA_ACC));

    assign o_Mem_Address      = acc_active ? addr_q  : '0;
    assign o_Mem_Write_Data   = acc_active ? wdata_q : '0;
    assign o_Mem_Read_Enable  = acc_active && !write_q;
    assign o_Mem_Write_Enable = acc_active && write_q && cnt_zero;

    assign o_Pipe_Done      = acc_active && cnt_zero && (state_q == PIPE_ACC);
    assign o_Dma_Done       = acc_active && cnt_zero && (state_q == DMA_ACC);
    assign o_Pipe_Read_Data = o_Pipe_Done ? i_Mem_Read_Data : '0;
    assign o_Dma_Read_Data  = o_Dma_Done  ? i_Mem_Read_Data : '0;
    assign o_Freeze         = pipe_req && !o_Pipe_Done;

`ifdef ARB_PERF_COUNT_EN
    logic [FREEZE_CNT_WIDTH-1:0]    freeze_cycles_q;
    logic [DMA_GRANT_CNT_WIDTH-1:0] dma_grants_q;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze_cycles_q <= '0;
            dma_grants_q    <= '0;
        end else begin
            if (o_Freeze && (freeze_cycles_q != '1)) begin
                freeze_cycles_q <= freeze_cycles_q + FREEZE_CNT_WIDTH'(1);
            end
            if ((state_q == IDLE) && (state_d == DMA_ACC) && (dma_grants_q != '1)) begin
                dma_grants_q <= dma_grants_q + DMA_GRANT_CNT_WIDTH'(1);
            end
        end
    end

    assign o_Freeze_Cycles = freeze_cycles_q;
    assign o_Dma_Grants    = dma_grants_q;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter (WAIT_CYCLES=2)
// with a small combinational-read memory model on the memory port.
module tb_data_memory_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_en, wr_en;
    logic [DW-1:0] p_addr, p_wdata, p_rdata;
    logic          p_done, freeze;
    logic          d_req, d_wr;
    logic [DW-1:0] d_addr, d_wdata, d_rdata;
    logic          d_done;
    logic          m_re, m_we;
    logic [DW-1:0] m_addr, m_wdata, m_rdata;
`ifdef ARB_PERF_COUNT_EN
    logic [31:0]   freeze_cycles;
    logic [15:0]   dma_grants;
`endif

    logic [DW-1:0] mem [0:255];
    int            wr_count = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(
        .DATA_WIDTH  (32),
        .WAIT_CYCLES (2),
        .CNT_WIDTH   (4)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_Sig_Memory_Read_Enable  (rd_en),
        .i_Sig_Memory_Write_Enable (wr_en),
        .i_Pipe_Address            (p_addr),
        .i_Pipe_Write_Data         (p_wdata),
        .o_Pipe_Read_Data          (p_rdata),
        .o_Pipe_Done               (p_done),
        .o_Freeze                  (freeze),
        .i_Dma_Request             (d_req),
        .i_Dma_Write               (d_wr),
        .i_Dma_Address             (d_addr),
        .i_Dma_Write_Data          (d_wdata),
        .o_Dma_Read_Data           (d_rdata),
        .o_Dma_Done                (d_done),
        .o_Mem_Read_Enable         (m_re),
        .o_Mem_Write_Enable        (m_we),
        .o_Mem_Address             (m_addr),
        .o_Mem_Write_Data          (m_wdata),
        .i_Mem_Read_Data           (m_rdata)
`ifdef ARB_PERF_COUNT_EN
        ,
        .o_Freeze_Cycles           (freeze_cycles),
        .o_Dma_Grants              (dma_grants)
`endif
    );

    assign m_rdata = mem[m_addr[7:0]];

    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr[7:0]] <= m_wdata;
            wr_count         <= wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        rd_en = rd; wr_en = wr; p_addr = a; p_wdata = d;
    endtask

    task automatic set_dma(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
        d_req = rq; d_wr = wr; d_addr = a; d_wdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_pipe(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;

        // Reset state, then freeze follows pipe_req while still in reset
        reset = 1'b1;
        set_pipe(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        tick();
        @(negedge clk);
        check_eq("rst_mem_re", 32'(m_re), 0);
        check_eq("rst_mem_we", 32'(m_we), 0);
        check_eq("rst_mem_addr", m_addr, 0);
        check_eq("rst_freeze_idle", 32'(freeze), 0);
        tick();
        set_pipe(1, 0, 32'h10, 0);
        @(negedge clk);
        check_eq("rst_freeze_req", 32'(freeze), 1);
        check_eq("rst_pipe_done", 32'(p_done), 0);
        check_eq("rst_mem_re_req", 32'(m_re), 0);
        tick();
        reset = 1'b0;

        // Uncontended pipeline read of 0x10
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("rd_freeze", 32'(freeze), 32'(c < 3));
            check_eq("rd_done", 32'(p_done), 32'(c == 3));
            check_eq("rd_mem_re", 32'(m_re), 32'(c >= 1));
            check_eq("rd_mem_addr", m_addr, (c >= 1) ? 32'h10 : 32'h0);
            check_eq("rd_data", p_rdata, (c == 3) ? 32'hDEADBEEF : 32'h0);
            tick();
        end
        set_pipe(0, 0, 0, 0);
        tick();

        // Pipeline write 0x20 <- 0x12345678, exactly one write pulse
        wc0 = wr_count;
        set_pipe(0, 1, 32'h20, 32'h12345678);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("wr_mem_we", 32'(m_we), 32'(c == 3));
            check_eq("wr_done", 32'(p_done), 32'(c == 3));
            check_eq("wr_freeze", 32'(freeze), 32'(c < 3));
            tick();
        end
        set_pipe(0, 0, 0, 0);
        check_eq("wr_count", 32'(wr_count - wc0), 1);

        // DMA read back of 0x20
        set_dma(1, 0, 32'h20, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("dmard_done", 32'(d_done), 32'(c == 3));
            check_eq("dmard_data", d_rdata, (c == 3) ? 32'h12345678 : 32'h0);
            check_eq("dmard_freeze", 32'(freeze), 0);
            tick();
        end
        set_dma(0, 0, 0, 0);
        tick();

        // Contention after reset: pipe wins, then DMA wins the next tie
        do_reset();
        set_pipe(1, 0, 32'h10, 0);
        set_dma(1, 0, 32'h10, 0);
        for (int c = 0; c < 12; c++) begin
            if (c == 4) set_pipe(1, 0, 32'h20, 0);
            if (c == 8) set_dma(0, 0, 0, 0);
            @(negedge clk);
            check_eq("arb_pipe_done", 32'(p_done), 32'((c == 3) || (c == 11)));
            check_eq("arb_dma_done", 32'(d_done), 32'(c == 7));
            check_eq("arb_freeze", 32'(freeze), 32'((c != 3) && (c != 11)));
            if (c == 3)  check_eq("arb_pipe_data1", p_rdata, 32'hDEADBEEF);
            if (c == 7)  check_eq("arb_dma_data", d_rdata, 32'hDEADBEEF);
            if (c == 11) check_eq("arb_pipe_data2", p_rdata, 32'h12345678);
            tick();
        end
        set_pipe(0, 0, 0, 0);
        tick();

        // DMA write in flight when pipeline read of the same word arrives
        wc0 = wr_count;
        set_dma(1, 1, 32'h30, 32'hCAFEF00D);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) set_pipe(1, 0, 32'h30, 0);
            if (c == 4) set_dma(0, 0, 0, 0);
            @(negedge clk);
            check_eq("dmaw_dma_done", 32'(d_done), 32'(c == 3));
            check_eq("dmaw_pipe_done", 32'(p_done), 32'(c == 7));
            check_eq("dmaw_freeze", 32'(freeze), 32'((c >= 1) && (c < 7)));
            check_eq("dmaw_mem_we", 32'(m_we), 32'(c == 3));
            if (c == 7) check_eq("dmaw_pipe_data", p_rdata, 32'hCAFEF00D);
            tick();
        end
        set_pipe(0, 0, 0, 0);
        check_eq("dmaw_wr_count", 32'(wr_count - wc0), 1);
        tick();

        // Reset in the second ACC cycle of a write aborts it
        wc0 = wr_count;
        set_pipe(0, 1, 32'h40, 32'h00000055);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_mem_we", 32'(m_we), 0);
        check_eq("abort_mem_addr", m_addr, 0);
        check_eq("abort_mem_wdata", m_wdata, 0);
        check_eq("abort_freeze", 32'(freeze), 1);
        tick();
        reset = 1'b0;
        set_pipe(0, 0, 0, 0);
        @(negedge clk);
        check_eq("abort_idle_re", 32'(m_re), 0);
        check_eq("abort_idle_we", 32'(m_we), 0);
        check_eq("abort_idle_addr", m_addr, 0);
        check_eq("abort_idle_done", 32'(p_done), 0);
        tick();
        check_eq("abort_wr_count", 32'(wr_count - wc0), 0);
        set_pipe(1, 0, 32'h40, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("abort_rd_done", 32'(p_done), 32'(c == 3));
            if (c == 3) check_eq("abort_rd_data", p_rdata, 0);
            tick();
        end
        set_pipe(0, 0, 0, 0);
        tick();

`ifdef ARB_PERF_COUNT_EN
        // Five back-to-back uncontended reads: 3 frozen cycles each
        do_reset();
        set_pipe(1, 0, 32'h10, 0);
        for (int c = 0; c < 20; c++) tick();
        set_pipe(0, 0, 0, 0);
        @(negedge clk);
        check_eq("perf_freeze_cycles", freeze_cycles, 15);
        check_eq("perf_dma_grants", 32'(dma_grants), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Sits between the MEM stage and data_memory. It shares the single data memory between two requesters: the pipeline MEM stage and a DMA/debug port. Each access takes a fixed number of wait cycles. The block sequences each access and asserts o_Freeze to stall the pipeline until the pipeline's own access completes.

Parameters:
DATA_WIDTH, 32, data and address width
WAIT_CYCLES, 2, extra memory cycles per access (legal 0..15)
CNT_WIDTH, 4, width of wait counter; must hold WAIT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
i_Sig_Memory_Read_Enable  in  1  pipeline read request (level, held while frozen)
i_Sig_Memory_Write_Enable  in  1  pipeline write request (level, held while frozen)
i_Pipe_Address  in  DATA_WIDTH  pipeline address (ALU result)
i_Pipe_Write_Data  in  DATA_WIDTH  pipeline store data (Rm value)
o_Pipe_Read_Data  out  DATA_WIDTH  load data; valid only when o_Pipe_Done=1
o_Pipe_Done  out  1  pipeline access completes this cycle
o_Freeze  out  1  stall IF/ID/EX/MEM registers
i_Dma_Request  in  1  DMA request (level, held until o_Dma_Done)
i_Dma_Write  in  1  1=write, 0=read
i_Dma_Address  in  DATA_WIDTH  DMA address
i_Dma_Write_Data  in  DATA_WIDTH  DMA store data
o_Dma_Read_Data  out  DATA_WIDTH  DMA load data; valid when o_Dma_Done=1
o_Dma_Done  out  1  DMA access completes this cycle
o_Mem_Read_Enable  out  1  to data_memory
o_Mem_Write_Enable  out  1  to data_memory
o_Mem_Address  out  DATA_WIDTH  to data_memory
o_Mem_Write_Data  out  DATA_WIDTH  to data_memory
i_Mem_Read_Data  in  DATA_WIDTH  from data_memory (combinational read)

Behaviour:
- Pipeline request (pipe_req) = read_en | write_en. If both are high, the access is treated as a write.
- FSM states:
  - IDLE: arbitrate among pending requests.
  - PIPE_ACC: serve the pipeline.
  - DMA_ACC: serve the DMA port.
- Arbitration in IDLE is round-robin using a registered last_grant bit (reset = DMA, so the pipeline wins the first tie).
  - One requester only: grant it.
  - Both requesting: grant the one not granted last.
  - On grant: load wait counter = WAIT_CYCLES, latch the requester's address, data and direction into registers, go to the ACC state.
- ACC state: drives o_Mem_Address, o_Mem_Write_Data and o_Mem_Read_Enable from the latched values every cycle.
  - Counter decrements each cycle.
  - When counter==0: assert done for the granted requester and return to IDLE.
  - ACC therefore lasts WAIT_CYCLES+1 cycles.
- o_Mem_Write_Enable pulses only in the final ACC cycle, giving exactly one write per access.
- Read data: o_Pipe_Read_Data / o_Dma_Read_Data = i_Mem_Read_Data, passed combinationally in the done cycle, 0 otherwise.
- o_Freeze = pipe_req & ~o_Pipe_Done (combinational). Timing for an uncontended pipeline access:
  - Request seen in IDLE at cycle 0.
  - Freeze is high cycles 0..WAIT_CYCLES.
  - Done at cycle WAIT_CYCLES+1, freeze low that cycle, pipeline advances.
  - If the DMA is mid-access, freeze stays high until the DMA completes and the pipeline access finishes.
- Requests are not re-sampled during ACC. Back-to-back requests always pass through one IDLE cycle.
- A requester dropping its request mid-access is ignored; the access completes.
- reset (synchronous):
  - State→IDLE, counter→0, last_grant→DMA.
  - All o_Mem_* outputs, done outputs and read data → 0.
  - Reset mid-access aborts with no memory write.
  - o_Freeze follows its combinational equation, so it is 1 if pipe_req is high.
- Outside ACC, all o_Mem_* outputs are 0.

Optional Feature:
Macro ARB_PERF_COUNT_EN.
- Defined: adds outputs o_Freeze_Cycles[31:0] and o_Dma_Grants[15:0].
  - o_Freeze_Cycles increments every cycle o_Freeze=1.
  - o_Dma_Grants increments on each DMA grant.
  - Both saturate at all-ones, reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg: FSM state encoding (IDLE=2'd0, PIPE_ACC=2'd1, DMA_ACC=2'd2), grant-owner constants (GRANT_PIPE=1'b0, GRANT_DMA=1'b1), default WAIT_CYCLES.
- One sub-module, mem_wait_counter: load/decrement/zero-flag counter of CNT_WIDTH bits. Everything else stays in the top.

Test Plan:
- Reset, then pipeline read addr 0x10, WAIT_CYCLES=2, memory word 0xDEADBEEF → o_Freeze high 3 cycles, o_Pipe_Done and o_Pipe_Read_Data=0xDEADBEEF in cycle 3.
- Pipeline write 0x20←0x12345678 → o_Mem_Write_Enable high exactly one cycle (cycle 3); later DMA read of 0x20 returns 0x12345678.
- Pipeline and DMA request in the same cycle after reset → pipeline served first. DMA done 4 cycles after pipeline done (1 IDLE + 3 ACC). A second simultaneous pair is served DMA first.
- DMA write in progress when pipeline read arrives → freeze held until the DMA completes plus the pipeline access; no lost or duplicated write.
- Reset asserted in the second ACC cycle of a write → no write pulse, FSM in IDLE next cycle, all o_Mem_* = 0.
- With ARB_PERF_COUNT_EN, 5 uncontended pipeline reads, WAIT_CYCLES=2 → o_Freeze_Cycles=15, o_Dma_Grants=0.
